// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
//   Run/step/halt controller for the CPU clock. Divides the board clock into a
//   50% duty-cycle clk_cpu whose half-period is programmable at runtime, and
//   offers a single-step mode driven by a debounced push-button. The CPU can
//   freeze its own clock by asserting hlt; the clock then parks low.
//
// Ports
//   clk          board clock, all registers on its rising edge
//   reset        synchronous, active-high
//   run_mode     raw switch, 1 = free-run, 0 = single-step (asynchronous)
//   step_btn     raw push-button, active-high (asynchronous, bouncy)
//   hlt          CPU halt request, synchronous to clk
//   half_period  clk cycles per clk_cpu phase (0 behaves as 1)
//   clk_cpu      CPU clock level (registered)
//   clk_rise     one-cycle strobe in the first cycle clk_cpu is 1
//   clk_fall     one-cycle strobe in the first cycle clk_cpu is 0 after high
//   halted       1 while parked low because of hlt
// -----------------------------------------------------------------------------

// Two-flop synchronizer followed by a level debouncer. The accepted level only
// flips after the synchronized input has disagreed with it for DEBOUNCE
// consecutive cycles; any agreeing cycle restarts the count.
module clock_ctrl_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE - 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end
endmodule

module clock_ctrl #(
  parameter int DEBOUNCE = 250000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             hlt,
  input  logic [CNT_W-1:0] half_period,
  output logic             clk_cpu,
  output logic             clk_rise,
  output logic             clk_fall,
  output logic             halted
);
  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] hp_eff;
  logic             run_eff;
  logic             btn_lvl;
  logic             btn_lvl_d;
  logic             step_ev;
  logic             phase_done;

  clock_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .raw   (run_mode),
    .level (run_eff)
  );

  clock_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (btn_lvl)
  );

  assign hp_eff     = (half_period == '0) ? CNT_W'(1) : half_period;
  // hp_q is never 0, so hp_q-1 cannot underflow and cnt stays below hp_q.
  assign phase_done = (cnt == hp_q - CNT_W'(1));
  assign step_ev    = btn_lvl & ~btn_lvl_d;

  // Whenever the LOW phase is held (halt or step mode), hp_q is refreshed so
  // the phase that eventually starts counting uses the current half_period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOW;
      cnt       <= '0;
      hp_q      <= hp_eff;
      btn_lvl_d <= 1'b0;
      clk_cpu   <= 1'b0;
      clk_rise  <= 1'b0;
      clk_fall  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      btn_lvl_d <= btn_lvl;
      clk_rise  <= 1'b0;
      clk_fall  <= 1'b0;
      halted    <= 1'b0;
      case (state)
        LOW: begin
          if (hlt) begin
            cnt    <= '0;
            hp_q   <= hp_eff;
            halted <= 1'b1;
          end else if (run_eff) begin
            if (phase_done) begin
              state    <= HIGH;
              cnt      <= '0;
              hp_q     <= hp_eff;
              clk_cpu  <= 1'b1;
              clk_rise <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt  <= '0;
            hp_q <= hp_eff;
            if (step_ev) begin
              state    <= HIGH;
              clk_cpu  <= 1'b1;
              clk_rise <= 1'b1;
            end
          end
        end
        HIGH: begin
          // A high phase always completes; step events arriving now are lost.
          if (phase_done) begin
            state    <= LOW;
            cnt      <= '0;
            hp_q     <= hp_eff;
            clk_cpu  <= 1'b0;
            clk_fall <= 1'b1;
            halted   <= hlt;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= LOW;
          cnt     <= '0;
          clk_cpu <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_ctrl
//   Directed scenarios plus a randomized stretch for clock_ctrl (DEBOUNCE = 4).
//   A reference model predicts the four outputs every cycle: input acceptance
//   is derived from the window of the last DEBOUNCE synchronized samples, and
//   each clk_cpu phase is tracked as a countdown of remaining cycles.
// -----------------------------------------------------------------------------
module tb_clock_ctrl;
  localparam int DB = 4;
  localparam int W  = 32;

  // clock / reset / DUT
  logic         clk = 1'b0;
  logic         reset;
  logic         run_mode;
  logic         step_btn;
  logic         hlt;
  logic [W-1:0] half_period;
  logic         clk_cpu;
  logic         clk_rise;
  logic         clk_fall;
  logic         halted;

  always #5 clk = ~clk;

  clock_ctrl #(.DEBOUNCE(DB), .CNT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_mode    (run_mode),
    .step_btn    (step_btn),
    .hlt         (hlt),
    .half_period (half_period),
    .clk_cpu     (clk_cpu),
    .clk_rise    (clk_rise),
    .clk_fall    (clk_fall),
    .halted      (halted)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_cnt, fall_cnt, high_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // reference model
  bit          rst_h[$];
  bit          run_h[$];
  bit          btn_h[$];
  logic [3:0]  exp_q[$];
  bit          m_run_acc, m_btn_acc, m_btn_prev;
  bit          m_level, m_rise, m_fall, m_halted;
  int unsigned m_left;

  // Value the conditioning logic compares at edge k: the raw input from two
  // edges earlier, or 0 if a reset cleared the synchronizer in between.
  function automatic bit seen_at(input int k, input bit sel);
    if (k < 2) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return sel ? btn_h[k-2] : run_h[k-2];
  endfunction

  // Accepted level flips at edge n when the last DB non-reset samples all
  // disagree with it.
  function automatic bit settle(input int n, input bit sel, input bit acc);
    for (int k = n - DB + 1; k <= n; k++) begin
      if (k < 0) return 1'b0;
      if (rst_h[k]) return 1'b0;
      if (seen_at(k, sel) == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit          ev;
    int unsigned hp;
    int          n;
    hp = (half_period == 0) ? 1 : half_period;
    rst_h.push_back(reset);
    run_h.push_back(run_mode);
    btn_h.push_back(step_btn);
    n = rst_h.size() - 1;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (reset) begin
      m_run_acc  = 1'b0;
      m_btn_acc  = 1'b0;
      m_btn_prev = 1'b0;
      m_level    = 1'b0;
      m_halted   = 1'b0;
      m_left     = hp;
    end else begin
      ev = m_btn_acc && !m_btn_prev;
      if (m_level) begin
        if (m_left == 1) begin
          m_level = 1'b0; m_fall = 1'b1; m_left = hp;
        end else m_left--;
      end else if (hlt) begin
        m_left = hp;
      end else if (m_run_acc) begin
        if (m_left == 1) begin
          m_level = 1'b1; m_rise = 1'b1; m_left = hp;
        end else m_left--;
      end else begin
        m_left = hp;
        if (ev) begin
          m_level = 1'b1; m_rise = 1'b1;
        end
      end
      m_halted   = hlt && !m_level;
      m_btn_prev = m_btn_acc;
      if (settle(n, 1'b0, m_run_acc)) m_run_acc = !m_run_acc;
      if (settle(n, 1'b1, m_btn_acc)) m_btn_acc = !m_btn_acc;
    end
    exp_q.push_back({m_level, m_rise, m_fall, m_halted});
  endtask

  // driver: one clk cycle, compare outputs on the falling edge
  task automatic tick();
    logic [3:0] e;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    check_eq("clk_cpu",  clk_cpu,  e[3]);
    check_eq("clk_rise", clk_rise, e[2]);
    check_eq("clk_fall", clk_fall, e[1]);
    check_eq("halted",   halted,   e[0]);
    if (clk_rise) rise_cnt++;
    if (clk_fall) fall_cnt++;
    if (clk_cpu)  high_cnt++;
  endtask

  task automatic clear_counts();
    rise_cnt = 0; fall_cnt = 0; high_cnt = 0;
  endtask

  task automatic wait_model_rise(input string tag);
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (!m_rise && i < 100);
    check_eq(tag, clk_rise, 1);
  endtask

  initial begin
    int last;
    int k;
    clear_counts();
    reset = 1'b1; run_mode = 1'b1; step_btn = 1'b0; hlt = 1'b0; half_period = 3;

    // reset: quiet during and one cycle after
    repeat (3) begin
      tick();
      check_eq("rst_quiet", {clk_cpu, clk_rise, clk_fall, halted}, 0);
    end
    reset = 1'b0;
    tick();
    check_eq("post_rst_quiet", {clk_cpu, clk_rise, clk_fall, halted}, 0);

    // free-run with half_period 3: strobes every 6 cycles, 3 high per period
    last = -1;
    repeat (60) begin
      tick();
      if (clk_rise) begin
        if (last >= 0) check_eq("rise_gap", cyc - last, 6);
        last = cyc;
      end
    end
    check_eq("free_run_rises", rise_cnt >= 8, 1);

    // half_period -> 0 in HIGH cycle 2: phase keeps length 3, then period 2
    wait_model_rise("wait_rise_hp");
    tick();
    half_period = 0;
    tick();
    check_eq("hp_mid_hold", clk_cpu, 1);
    tick();
    check_eq("hp_mid_fall", clk_fall, 1);
    tick();
    check_eq("hp0_rise", clk_rise, 1);
    last = cyc;
    repeat (10) begin
      tick();
      if (clk_rise) begin
        check_eq("rise_gap_hp0", cyc - last, 2);
        last = cyc;
      end
    end

    // halt raised in HIGH cycle 1
    half_period = 3;
    wait_model_rise("wait_rise_halt");
    hlt = 1'b1;
    tick(); check_eq("halt_high2", clk_cpu, 1);
    tick(); check_eq("halt_high3", clk_cpu, 1);
    tick(); check_eq("halt_fall", clk_fall, 1); check_eq("halt_first_low", halted, 1);
    repeat (20) begin
      tick();
      check_eq("halt_hold_clk", clk_cpu, 0);
      check_eq("halt_hold_flag", halted, 1);
    end
    hlt = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!clk_rise && k < 20);
    check_eq("halt_release_gap", k, 3);

    // step mode: bounces must not step
    run_mode = 1'b0;
    repeat (20) tick();
    clear_counts();
    repeat (4) begin
      step_btn = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      step_btn = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    repeat (15) tick();
    check_eq("bounce_no_rise", rise_cnt, 0);

    // clean press: one full high phase
    clear_counts();
    step_btn = 1'b1; repeat (50) tick();
    step_btn = 1'b0; repeat (20) tick();
    check_eq("press_rises", rise_cnt, 1);
    check_eq("press_falls", fall_cnt, 1);
    check_eq("press_high",  high_cnt, 3);

    // second press lands in a long HIGH phase and is dropped
    half_period = 20;
    clear_counts();
    step_btn = 1'b1; repeat (8)  tick();
    step_btn = 1'b0; repeat (6)  tick();
    step_btn = 1'b1; repeat (12) tick();
    step_btn = 1'b0; repeat (40) tick();
    check_eq("drop_rises", rise_cnt, 1);
    check_eq("drop_falls", fall_cnt, 1);
    check_eq("drop_high",  high_cnt, 20);

    // press while halted in step mode
    half_period = 3;
    hlt = 1'b1;
    repeat (5) tick();
    clear_counts();
    step_btn = 1'b1; repeat (20) tick();
    step_btn = 1'b0; repeat (20) tick();
    check_eq("halted_step_rises", rise_cnt, 0);
    check_eq("halted_step_flag", halted, 1);
    hlt = 1'b0;
    repeat (5) tick();

    // reset in HIGH cycle 2, then free-run resumes after debounce
    run_mode = 1'b1;
    repeat (15) tick();
    wait_model_rise("wait_rise_rst");
    tick();
    reset = 1'b1;
    tick();
    check_eq("rst_mid_clk", clk_cpu, 0);
    check_eq("rst_mid_fall", clk_fall, 0);
    reset = 1'b0;
    clear_counts();
    repeat (6) tick();
    check_eq("rst_mid_no_fall", fall_cnt, 0);
    repeat (20) tick();
    check_eq("rst_resume", rise_cnt != 0, 1);

    // randomized stretch
    repeat (1200) begin
      if ($urandom_range(0, 15) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 3) == 0)  step_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
      if ($urandom_range(0, 29) == 0) half_period = $urandom_range(0, 5);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
